// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: multiplexes a 16-bit value onto a 4-digit common-anode
// seven-segment display, one digit per slot, with per-slot dead time and
// double-buffered updates that commit only at frame boundaries.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   value_in     four hex digits, digit 0 in [3:0]
//   load         single-cycle strobe capturing value_in
//   blank_mask   bit d keeps digit d dark for its whole slot
//   out          nibble of the digit currently being driven (registered)
//   an           active-low one-hot anode enables (registered)
//   frame        one-cycle pulse on the first cycle of each frame (registered)
//   pending      a loaded value is waiting for the next frame boundary
module hex_digit_scanner #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  out,
  output logic [3:0]  an,
  output logic        frame,
  output logic        pending
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  // cnt_q/idx_q hold the slot position of the cycle currently shown on the
  // outputs; run_q is clear until the first edge after reset, which starts
  // slot 0 of frame 0 rather than advancing from it.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      stage_q, stage_d;
  logic             pending_q, pending_d;
  logic             run_q;
  logic [3:0]       out_q, out_d;
  logic [3:0]       an_q, an_d;
  logic             frame_q, frame_d;
  logic             boundary;

  // Next position, buffer commit and registered output values.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    disp_d    = disp_q;
    stage_d   = stage_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    out_d     = 4'h0;
    an_d      = 4'b1111;

    if (!run_q) begin
      cnt_d    = '0;
      idx_d    = 2'd0;
      boundary = 1'b1;
    end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d    = '0;
      idx_d    = idx_q + 2'd1;
      boundary = (idx_q == 2'd3);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A load on the boundary edge bypasses the older staged value.
    if (boundary) begin
      if (load) begin
        disp_d    = value_in;
        stage_d   = value_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = stage_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      stage_d   = value_in;
      pending_d = 1'b1;
    end

    // Outputs reflect the position being entered, using the committed disp.
    case (idx_d)
      2'd0:    out_d = disp_d[3:0];
      2'd1:    out_d = disp_d[7:4];
      2'd2:    out_d = disp_d[11:8];
      default: out_d = disp_d[15:12];
    endcase

    if ((32'(cnt_d) >= BLANK_CYCLES) && !blank_mask[idx_d]) begin
      case (idx_d)
        2'd0:    an_d = 4'b1110;
        2'd1:    an_d = 4'b1101;
        2'd2:    an_d = 4'b1011;
        default: an_d = 4'b0111;
      endcase
    end

    frame_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      disp_q    <= 16'h0000;
      stage_q   <= 16'h0000;
      pending_q <= 1'b0;
      run_q     <= 1'b0;
      out_q     <= 4'h0;
      an_q      <= 4'b1111;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      stage_q   <= stage_d;
      pending_q <= pending_d;
      run_q     <= 1'b1;
      out_q     <= out_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign out     = out_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with REFRESH_DIV=4, BLANK_CYCLES=1
// (16-cycle frames). cyc is the index of the cycle visible on the outputs,
// counted from the first edge after reset release.
module tb_hex_digit_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  out;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  int checks;
  int errors;
  int cyc;

  logic [3:0] an_first [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [3:0] an_mask2 [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'h7};

  hex_digit_scanner #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .load      (load),
    .blank_mask(blank_mask),
    .out       (out),
    .an        (an),
    .frame     (frame),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = -1;
    rst_n      = 1'b0;
    value_in   = 16'h0000;
    load       = 1'b0;
    blank_mask = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_an", 16'(an), 16'h000F);
    check("rst_out", 16'(out), 16'h0000);
    check("rst_frame", 16'(frame), 16'h0000);
    check("rst_pending", 16'(pending), 16'h0000);
    rst_n = 1'b1;

    // First frame anode pattern, frame pulses at cycles 0 and 16
    for (int c = 0; c <= 16; c++) begin
      tick();
      check("first_an", 16'(an), 16'(an_first[c % 16]));
      check("first_frame", 16'(frame), (c % 16 == 0) ? 16'h1 : 16'h0);
      check("first_out", 16'(out), 16'h0000);
    end

    // Load commit: load A5C3 in slot 1 of frame 1
    go_to(20);
    value_in = 16'hA5C3; load = 1'b1;
    tick();
    load = 1'b0;
    check("commit_pend_rise", 16'(pending), 16'h1);
    check("commit_out_old", 16'(out), 16'h0);
    go_to(31);
    check("commit_pend_hold", 16'(pending), 16'h1);
    tick();
    check("commit_frame", 16'(frame), 16'h1);
    check("commit_pend_fall", 16'(pending), 16'h0);
    check("commit_d0", 16'(out), 16'h3);
    go_to(33); check("commit_an0", 16'(an), 16'hE);
    go_to(36); check("commit_d1", 16'(out), 16'hC);
    go_to(40); check("commit_d2", 16'(out), 16'h5);
    go_to(44); check("commit_d3", 16'(out), 16'hA);

    // Last write wins: 1111 then 2222 in frame starting at 48
    go_to(50);
    value_in = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    go_to(54);
    value_in = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    check("lww_pend", 16'(pending), 16'h1);
    go_to(56); check("lww_hold_d2", 16'(out), 16'h5);
    go_to(60); check("lww_hold_d3", 16'(out), 16'hA);
    go_to(64); check("lww_d0", 16'(out), 16'h2);
    check("lww_pend_fall", 16'(pending), 16'h0);
    go_to(68); check("lww_d1", 16'(out), 16'h2);
    go_to(72); check("lww_d2", 16'(out), 16'h2);
    go_to(76); check("lww_d3", 16'(out), 16'h2);

    // Load on the boundary edge while stage holds 1234
    go_to(82);
    value_in = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    check("bnd_pend", 16'(pending), 16'h1);
    go_to(95);
    value_in = 16'hBEEF; load = 1'b1;
    tick();
    load = 1'b0;
    check("bnd_frame", 16'(frame), 16'h1);
    check("bnd_pend_fall", 16'(pending), 16'h0);
    check("bnd_d0", 16'(out), 16'hF);
    go_to(100); check("bnd_d1", 16'(out), 16'hE);
    go_to(104); check("bnd_d2", 16'(out), 16'hE);
    go_to(108); check("bnd_d3", 16'(out), 16'hB);
    check("bnd_pend_low", 16'(pending), 16'h0);

    // Blanking digit 2 for the frame starting at 112
    go_to(111);
    blank_mask = 4'b0100;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("mask_an", 16'(an), 16'(an_mask2[c]));
    end
    go_to(137);
    check("mask_mid_dark", 16'(an), 16'hF);
    blank_mask = 4'b0000;
    tick();
    check("mask_clear", 16'(an), 16'hB);
    tick();
    check("mask_clear_hold", 16'(an), 16'hB);

    // Reset mid-operation in slot 2 with a pending load
    go_to(145);
    value_in = 16'h5A5A; load = 1'b1;
    tick();
    load = 1'b0;
    go_to(153);
    check("mid_pre_pend", 16'(pending), 16'h1);
    check("mid_pre_out", 16'(out), 16'hE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 16'(an), 16'hF);
    check("mid_rst_out", 16'(out), 16'h0);
    check("mid_rst_frame", 16'(frame), 16'h0);
    check("mid_rst_pend", 16'(pending), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    tick();
    check("post_frame", 16'(frame), 16'h1);
    check("post_an", 16'(an), 16'hF);
    for (int c = 0; c < 32; c += 4) begin
      go_to(c + 1);
      check("post_out", 16'(out), 16'h0);
      check("post_pend", 16'(pending), 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case the bench itself stalls
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
